// File: rtl/brick_store.sv
// brick_store: brick grid memory for the collision logic.
// Maps pixel probes to grid cells, returns the cell origin and health one
// cycle later, takes health write-backs, tracks the live brick count and
// queues erase events for the drawing stage.
module brick_store #(
  parameter int BRICKX      = 40,
  parameter int BRICKY      = 20,
  parameter int COLS        = 16,
  parameter int ROWS        = 8,
  parameter int INIT_HEALTH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       rd_x,
  input  logic [9:0]       rd_y,
  output logic [9:0]       brick_x,
  output logic [9:0]       brick_y,
  output logic [1:0]       brick_health,
  input  logic             wr_en,
  input  logic [9:0]       wr_x,
  input  logic [9:0]       wr_y,
  input  logic [1:0]       wr_health,
  output logic             init_busy,
  output logic [CNT_W-1:0] bricks_left,
  output logic             level_clear,
  output logic             erase_valid,
  output logic [9:0]       erase_x,
  output logic [9:0]       erase_y,
  input  logic             erase_ready,
  output logic             erase_overflow
);

  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [1:0]       mem [CELLS];
  logic [0:0]       state;
  logic [IDX_W-1:0] init_idx;

  // Cell mapping for the probe and write ports
  logic [9:0]       rd_col, rd_row, wr_col, wr_row;
  logic             rd_in, wr_in;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [9:0]       rd_ox, rd_oy, wr_ox, wr_oy;

  // Write classification against the current (old) cell health
  logic       wr_fire;
  logic [1:0] old_health;
  logic       destroy, revive;

  // Erase FIFO, two entries
  logic [9:0] fifo_x [2];
  logic [9:0] fifo_y [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] fifo_cnt;
  logic       pop, push_ok;

  // Address decode: constant division by the brick size, then bounds check
  always_comb begin
    rd_col = rd_x / 10'(BRICKX);
    rd_row = rd_y / 10'(BRICKY);
    wr_col = wr_x / 10'(BRICKX);
    wr_row = wr_y / 10'(BRICKY);
    rd_in  = (rd_col < 10'(COLS)) && (rd_row < 10'(ROWS));
    wr_in  = (wr_col < 10'(COLS)) && (wr_row < 10'(ROWS));
    rd_idx = IDX_W'(32'(rd_row) * COLS + 32'(rd_col));
    wr_idx = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));
    rd_ox  = 10'(32'(rd_col) * BRICKX);
    rd_oy  = 10'(32'(rd_row) * BRICKY);
    wr_ox  = 10'(32'(wr_col) * BRICKX);
    wr_oy  = 10'(32'(wr_row) * BRICKY);
  end

  // Write-back qualification; external writes only land once init is done
  always_comb begin
    wr_fire    = wr_en && wr_in && (state == S_RUN) && !reset;
    old_health = wr_fire ? mem[wr_idx] : 2'd0;
    destroy    = wr_fire && (old_health != 2'd0) && (wr_health == 2'd0);
    revive     = wr_fire && (old_health == 2'd0) && (wr_health != 2'd0);
  end

  // Init sequencer: one cell per cycle, then run until the next reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_idx <= '0;
    end else if (state == S_INIT) begin
      if (init_idx == IDX_W'(CELLS - 1)) state <= S_RUN;
      else                               init_idx <= init_idx + 1'b1;
    end
  end

  // Grid storage: init fill takes priority, otherwise the write-back port
  always_ff @(posedge clk) begin
    if (!reset && state == S_INIT) mem[init_idx] <= 2'(INIT_HEALTH);
    else if (wr_fire)              mem[wr_idx]   <= wr_health;
  end

  // Registered probe result; reads the pre-write value on a same-cell write
  always_ff @(posedge clk) begin
    if (reset) begin
      brick_x      <= '0;
      brick_y      <= '0;
      brick_health <= '0;
    end else begin
      brick_x      <= rd_in ? rd_ox : 10'd0;
      brick_y      <= rd_in ? rd_oy : 10'd0;
      brick_health <= (rd_in && state == S_RUN) ? mem[rd_idx] : 2'd0;
    end
  end

  // Live brick count follows zero/nonzero transitions of cell health
  always_ff @(posedge clk) begin
    if (reset)        bricks_left <= CNT_W'(CELLS);
    else if (destroy) bricks_left <= bricks_left - 1'b1;
    else if (revive)  bricks_left <= bricks_left + 1'b1;
  end

  // Erase handshake: an event transfers on a rising edge where erase_valid
  // and erase_ready are both high; erase_x/erase_y are stable while
  // erase_valid is high and erase_ready is low. A pop frees a slot for a
  // push in the same cycle, so a full FIFO drops nothing in that case.
  always_comb begin
    erase_valid = (fifo_cnt != 2'd0);
    erase_x     = fifo_x[rd_ptr];
    erase_y     = fifo_y[rd_ptr];
    pop         = erase_valid && erase_ready;
    push_ok     = destroy && ((fifo_cnt != 2'd2) || pop);
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      fifo_cnt       <= 2'd0;
      erase_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (destroy && !push_ok) erase_overflow <= 1'b1;
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_x[wr_ptr] <= wr_ox;
      fifo_y[wr_ptr] <= wr_oy;
    end
  end

  assign init_busy   = (state == S_INIT);
  assign level_clear = (bricks_left == '0) && !init_busy;

endmodule

// File: tb/tb_brick_store.sv
// Directed testbench for brick_store: init sequencing, probes, write-backs,
// brick counting, erase FIFO behaviour and level clear.
module tb_brick_store;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] rd_x, rd_y;
  logic [9:0] brick_x, brick_y;
  logic [1:0] brick_health;
  logic       wr_en;
  logic [9:0] wr_x, wr_y;
  logic [1:0] wr_health;
  logic       init_busy;
  logic [7:0] bricks_left;
  logic       level_clear;
  logic       erase_valid;
  logic [9:0] erase_x, erase_y;
  logic       erase_ready;
  logic       erase_overflow;

  int checks   = 0;
  int failures = 0;

  brick_store dut (
    .clk(clk), .reset(reset),
    .rd_x(rd_x), .rd_y(rd_y),
    .brick_x(brick_x), .brick_y(brick_y), .brick_health(brick_health),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_health(wr_health),
    .init_busy(init_busy), .bricks_left(bricks_left), .level_clear(level_clear),
    .erase_valid(erase_valid), .erase_x(erase_x), .erase_y(erase_y),
    .erase_ready(erase_ready), .erase_overflow(erase_overflow)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks: entered and left on a falling edge
  task automatic do_write(input int x, input int y, input int h);
    wr_en = 1'b1; wr_x = 10'(x); wr_y = 10'(y); wr_health = 2'(h);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_probe(input int x, input int y);
    rd_x = 10'(x); rd_y = 10'(y);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", init_busy); end
    checks++; if (bricks_left !== 8'd128) begin failures++; $display("FAIL rst_left got=%0d exp=128", bricks_left); end
    checks++; if (level_clear !== 1'b0) begin failures++; $display("FAIL rst_clear got=%b exp=0", level_clear); end
    checks++; if (erase_valid !== 1'b0 || erase_overflow !== 1'b0) begin failures++; $display("FAIL rst_erase got=%b%b exp=00", erase_valid, erase_overflow); end
    checks++; if (brick_health !== 2'd0 || brick_x !== 10'd0) begin failures++; $display("FAIL rst_read got=%0d,%0d exp=0,0", brick_health, brick_x); end
    rd_x = 10'd0; rd_y = 10'd0;
    reset = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      n++;
      if (n == 5) begin
        checks++; if (brick_health !== 2'd0) begin failures++; $display("FAIL init_read got=%0d exp=0", brick_health); end
      end
      @(negedge clk);
    end
    checks++; if (n != 128) begin failures++; $display("FAIL init_cycles got=%0d exp=128", n); end
    checks++; if (bricks_left !== 8'd128 || level_clear !== 1'b0) begin failures++; $display("FAIL init_left got=%0d/%b exp=128/0", bricks_left, level_clear); end
  endtask

  task automatic test_read();
    do_probe(85, 45);
    checks++; if (brick_x !== 10'd80 || brick_y !== 10'd40 || brick_health !== 2'd3) begin failures++; $display("FAIL read_85_45 got=%0d,%0d,%0d exp=80,40,3", brick_x, brick_y, brick_health); end
    do_probe(700, 10);
    checks++; if (brick_x !== 10'd0 || brick_y !== 10'd0 || brick_health !== 2'd0) begin failures++; $display("FAIL read_700_10 got=%0d,%0d,%0d exp=0,0,0", brick_x, brick_y, brick_health); end
    do_probe(639, 159);
    checks++; if (brick_x !== 10'd600 || brick_y !== 10'd140 || brick_health !== 2'd3) begin failures++; $display("FAIL read_corner got=%0d,%0d,%0d exp=600,140,3", brick_x, brick_y, brick_health); end
    do_probe(640, 0);
    checks++; if (brick_health !== 2'd0 || brick_x !== 10'd0) begin failures++; $display("FAIL read_x_edge got=%0d,%0d exp=0,0", brick_health, brick_x); end
    do_probe(0, 160);
    checks++; if (brick_health !== 2'd0 || brick_y !== 10'd0) begin failures++; $display("FAIL read_y_edge got=%0d,%0d exp=0,0", brick_health, brick_y); end
  endtask

  task automatic test_write();
    erase_ready = 1'b0;
    do_write(85, 45, 2);
    checks++; if (bricks_left !== 8'd128 || erase_valid !== 1'b0) begin failures++; $display("FAIL wr_h2 got=%0d/%b exp=128/0", bricks_left, erase_valid); end
    do_write(85, 45, 1);
    checks++; if (bricks_left !== 8'd128) begin failures++; $display("FAIL wr_h1 got=%0d exp=128", bricks_left); end
    do_write(85, 45, 0);
    checks++; if (bricks_left !== 8'd127) begin failures++; $display("FAIL wr_h0 got=%0d exp=127", bricks_left); end
    checks++; if (erase_valid !== 1'b1 || erase_x !== 10'd80 || erase_y !== 10'd40) begin failures++; $display("FAIL erase_evt got=%b,%0d,%0d exp=1,80,40", erase_valid, erase_x, erase_y); end
    repeat (3) @(negedge clk);
    checks++; if (erase_valid !== 1'b1 || erase_x !== 10'd80) begin failures++; $display("FAIL erase_hold got=%b,%0d exp=1,80", erase_valid, erase_x); end
    erase_ready = 1'b1;
    @(negedge clk);
    erase_ready = 1'b0;
    checks++; if (erase_valid !== 1'b0) begin failures++; $display("FAIL erase_pop got=%b exp=0", erase_valid); end
    do_probe(85, 45);
    checks++; if (brick_health !== 2'd0 || brick_x !== 10'd80) begin failures++; $display("FAIL wr_readback got=%0d,%0d exp=0,80", brick_health, brick_x); end
  endtask

  task automatic test_read_during_write();
    rd_x = 10'd0; rd_y = 10'd0;
    wr_en = 1'b1; wr_x = 10'd0; wr_y = 10'd0; wr_health = 2'd2;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (brick_health !== 2'd3) begin failures++; $display("FAIL rdw_old got=%0d exp=3", brick_health); end
    @(negedge clk);
    checks++; if (brick_health !== 2'd2) begin failures++; $display("FAIL rdw_new got=%0d exp=2", brick_health); end
    checks++; if (bricks_left !== 8'd127) begin failures++; $display("FAIL rdw_left got=%0d exp=127", bricks_left); end
  endtask

  task automatic test_back_to_back();
    erase_ready = 1'b0;
    do_write(120, 0, 0);
    do_write(160, 0, 0);
    erase_ready = 1'b1;
    do_write(200, 0, 0);
    checks++; if (erase_valid !== 1'b1 || erase_x !== 10'd160 || erase_overflow !== 1'b0) begin failures++; $display("FAIL b2b_head got=%b,%0d,%b exp=1,160,0", erase_valid, erase_x, erase_overflow); end
    checks++; if (bricks_left !== 8'd124) begin failures++; $display("FAIL b2b_left got=%0d exp=124", bricks_left); end
    @(negedge clk);
    checks++; if (erase_valid !== 1'b1 || erase_x !== 10'd200 || erase_y !== 10'd0) begin failures++; $display("FAIL b2b_second got=%b,%0d,%0d exp=1,200,0", erase_valid, erase_x, erase_y); end
    @(negedge clk);
    checks++; if (erase_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", erase_valid); end
    erase_ready = 1'b0;
  endtask

  task automatic test_overflow();
    erase_ready = 1'b0;
    do_write(0, 0, 0);
    do_write(40, 0, 0);
    do_write(80, 0, 0);
    checks++; if (erase_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", erase_overflow); end
    checks++; if (bricks_left !== 8'd121) begin failures++; $display("FAIL ovf_left got=%0d exp=121", bricks_left); end
    checks++; if (erase_valid !== 1'b1 || erase_x !== 10'd0 || erase_y !== 10'd0) begin failures++; $display("FAIL ovf_head0 got=%b,%0d,%0d exp=1,0,0", erase_valid, erase_x, erase_y); end
    erase_ready = 1'b1;
    @(negedge clk);
    checks++; if (erase_valid !== 1'b1 || erase_x !== 10'd40) begin failures++; $display("FAIL ovf_head1 got=%b,%0d exp=1,40", erase_valid, erase_x); end
    @(negedge clk);
    checks++; if (erase_valid !== 1'b0 || erase_overflow !== 1'b1) begin failures++; $display("FAIL ovf_drain got=%b,%b exp=0,1", erase_valid, erase_overflow); end
    erase_ready = 1'b0;
  endtask

  task automatic test_clear();
    do_write(700, 10, 0);
    checks++; if (bricks_left !== 8'd121) begin failures++; $display("FAIL oob_write got=%0d exp=121", bricks_left); end
    erase_ready = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        do_write(c * 40, r * 20, 0);
    checks++; if (bricks_left !== 8'd0 || level_clear !== 1'b1) begin failures++; $display("FAIL clear_all got=%0d/%b exp=0/1", bricks_left, level_clear); end
    do_write(0, 0, 1);
    checks++; if (bricks_left !== 8'd1 || level_clear !== 1'b0) begin failures++; $display("FAIL revive got=%0d/%b exp=1/0", bricks_left, level_clear); end
    erase_ready = 1'b0;
  endtask

  task automatic test_mid_init_reset();
    int n;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", init_busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b1; wr_x = 10'd0; wr_y = 10'd0; wr_health = 2'd0;
    n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++; if (n != 128) begin failures++; $display("FAIL mid_cycles got=%0d exp=128", n); end
    checks++; if (bricks_left !== 8'd128 || erase_overflow !== 1'b0 || erase_valid !== 1'b0) begin failures++; $display("FAIL mid_state got=%0d,%b,%b exp=128,0,0", bricks_left, erase_overflow, erase_valid); end
    do_probe(0, 0);
    checks++; if (brick_health !== 2'd3) begin failures++; $display("FAIL mid_probe got=%0d exp=3", brick_health); end
  endtask

  // Test sequence
  initial begin
    reset = 1'b1; rd_x = '0; rd_y = '0;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_health = '0;
    erase_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_read_during_write();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_mid_init_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brick_store.md
Name: brick_store

Overview:
- Brick-grid memory stage that directly serves the ball collision logic.
- Takes pixel probe coordinates, converts them to a grid cell, and returns the brick's snapped origin and health one cycle later.
- Accepts health write-backs and maintains the live brick count and a level-clear flag.
- Queues erase events for the VGA drawing stage whenever a brick is destroyed.

Parameters:
- BRICKX, 40, brick width in pixels.
- BRICKY, 20, brick height in pixels.
- COLS, 16, grid columns (the grid occupies x in [0, COLS*BRICKX)).
- ROWS, 8, grid rows (the grid occupies y in [0, ROWS*BRICKY)).
- INIT_HEALTH, 3, health loaded into every cell at init (1..3).
- CNT_W, 8, width of bricks_left; must hold COLS*ROWS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rd_x  in  10  probe x pixel.
- rd_y  in  10  probe y pixel.
- brick_x  out  10  snapped cell origin x (col*BRICKX).
- brick_y  out  10  snapped cell origin y (row*BRICKY).
- brick_health  out  2  health of the probed cell.
- wr_en  in  1  health write strobe.
- wr_x  in  10  write x pixel.
- wr_y  in  10  write y pixel.
- wr_health  in  2  new health value.
- init_busy  out  1  high while the grid is being initialised.
- bricks_left  out  CNT_W  count of cells with nonzero health.
- level_clear  out  1  bricks_left==0 and init done.
- erase_valid  out  1  erase event available.
- erase_x  out  10  origin x of the destroyed brick.
- erase_y  out  10  origin y of the destroyed brick.
- erase_ready  in  1  consumer accepts the erase event.
- erase_overflow  out  1  sticky flag: an erase event was dropped.

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset.
- Reset values: all outputs 0 except init_busy=1 and bricks_left=COLS*ROWS. Erase FIFO emptied, overflow cleared.
- Cell mapping: col=x/BRICKX, row=y/BRICKY (constant division). idx=row*COLS+col. In-grid iff col<COLS and row<ROWS.
- FSM S_INIT:
  - Entered on reset; idx counter runs 0..COLS*ROWS-1, one write of INIT_HEALTH per cycle.
  - init_busy=1; external writes ignored; reads return health 0.
  - After the last cell, go to S_RUN; init_busy drops the cycle after the last write.
  - Reset asserted mid-init restarts from idx 0.
- FSM S_RUN:
  - Normal operation; no return to S_INIT except via reset.
- Read:
  - Registered, latency 1. Outputs at cycle t+1 reflect rd_x/rd_y sampled at cycle t.
  - Out-of-grid probe: brick_health=0, brick_x=brick_y=0.
- Write:
  - Committed at the edge where wr_en=1; out-of-grid writes are ignored.
  - Read-during-write to the same cell in the same cycle returns the OLD value; the new value is visible from the next probe.
- Count:
  - Old!=0 and new==0: bricks_left-1 and push an erase event (cell origin).
  - Old==0 and new!=0: bricks_left+1, no event.
  - Otherwise: count unchanged.
  - Count never wraps; by construction it stays in 0..COLS*ROWS.
- Erase FIFO:
  - 2 entries; erase_valid = not empty; erase_x/erase_y show the head entry.
  - Pop when erase_valid and erase_ready.
  - Push and pop in the same cycle on a full FIFO is legal and drops nothing.
  - Push while full with no pop: event dropped, erase_overflow set (held until reset).
- level_clear is combinational from bricks_left==0 and !init_busy.

Test Plan:
- Reset, hold low 128 cycles -> init_busy=1 for exactly 128 cycles then 0; bricks_left=128; level_clear=0.
- Probe (85,45) -> next cycle brick_x=80, brick_y=40, brick_health=3. Probe (700,10) -> health 0, origin (0,0).
- Write (85,45) health 2, then 1, then 0 -> bricks_left 128,128,127. One erase event (80,40) appears with erase_ready=0 and holds until erase_ready=1, then erase_valid=0.
- Same-cycle probe and write at (0,0), health 3->2 -> probe returns 3; a probe on the following cycle returns 2.
- With erase_ready=0, destroy 3 bricks -> FIFO holds the first two, erase_overflow=1. Then raise erase_ready -> the two events drain in order.
- Destroy all 128 bricks -> level_clear=1. Write health 1 to one cell -> bricks_left=1, level_clear=0. Reset mid-init at idx 50 -> init restarts, 128 further busy cycles.
